// File: rtl/dram_device.sv
// dram_device: cycle-based behavioural model of an off-chip DRAM.
// It has a multiplexed RAS/CAS address bus and a 32-bit data path with
// per-byte write enables.
//
// The storage is held as four byte arrays, Memory_byte0 (bits 7:0) through
// Memory_byte3 (bits 31:24). Each array is indexed by the word index {row, col}.
// The arrays are never cleared by reset, so a bench can preload and inspect
// them hierarchically.
//
// Optional build macro: DRAM_TIMING_CHECK_EN
//   When defined, the model enforces tRCD. It drops CAS commands issued to a
//   closed row and reports each one with $error. Each instance counts these
//   in violation_count.
//   When undefined, a CAS with an open row executes immediately, and an
//   ignored CAS is silent.
//
// Ports:
//   CK     in   clock, all sampling on the rising edge
//   RST    in   asynchronous active-high reset
//   CSn    in   chip select, active-low
//   RASn   in   row strobe, active-low (high = precharge)
//   CASn   in   column strobe, active-low
//   WEn    in   [3:0] per-byte write enable, active-low; all ones = read
//   A      in   [ROW_W-1:0] row address (RAS) / column address in low COL_W bits (CAS)
//   D      in   [31:0] write data
//   Q      out  [31:0] read data, holds the last read value
//   VALID  out  one-cycle strobe, Q carries read data this cycle
module dram_device #(
    parameter int ROW_W   = 11,
    parameter int COL_W   = 10,
    parameter int CAS_LAT = 5,
    parameter int TRCD    = 2
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             CSn,
    input  logic             RASn,
    input  logic             CASn,
    input  logic [3:0]       WEn,
    input  logic [ROW_W-1:0] A,
    input  logic [31:0]      D,
    output logic [31:0]      Q,
    output logic             VALID
);

    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    logic [7:0] Memory_byte0 [0:DEPTH-1];
    logic [7:0] Memory_byte1 [0:DEPTH-1];
    logic [7:0] Memory_byte2 [0:DEPTH-1];
    logic [7:0] Memory_byte3 [0:DEPTH-1];

    logic             prev_RASn;
    logic             prev_CASn;
    logic             row_open;
    logic [ROW_W-1:0] row_q;
    logic [CAS_LAT-1:0] vld_pipe_q;
    logic [31:0]      data_pipe_q [CAS_LAT];
    logic [31:0]      q_q;
    logic             valid_q;

    logic             act;
    logic             cas_fall;
    logic             cas_ok;
    logic             rd_cmd;
    logic             wr_cmd;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word;

    // Strobes are edge-detected against the previous cycle's sample. The edge
    // registers track the pins even while the chip is deselected.
    assign act      = !CSn && prev_RASn && !RASn;
    assign cas_fall = !CSn && prev_CASn && !CASn;

`ifdef DRAM_TIMING_CHECK_EN
    localparam int CNTW = $clog2(TRCD + 1) + 1;
    localparam logic [CNTW-1:0] TRCD_C = CNTW'(TRCD);

    // Counts the cycles elapsed since activation, saturating at TRCD.
    logic [CNTW-1:0] rcd_cnt_q;
    integer          violation_count;
    logic            viol;

    assign viol   = cas_fall && (!row_open || RASn || (rcd_cnt_q < TRCD_C));
    assign cas_ok = cas_fall && !viol;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            rcd_cnt_q       <= '0;
            violation_count <= 0;
        end else begin
            if (act)
                rcd_cnt_q <= CNTW'(1);
            else if (rcd_cnt_q < TRCD_C)
                rcd_cnt_q <= rcd_cnt_q + CNTW'(1);
            if (viol) begin
                violation_count <= violation_count + 1;
                $error("%0t dram_device: CAS dropped (row_open=%0b trcd_cnt=%0d) A=%h",
                       $time, row_open, rcd_cnt_q, A);
            end
        end
    end
`else
    assign cas_ok = cas_fall && row_open && !RASn;
`endif

    assign rd_cmd  = cas_ok && (WEn == 4'hF);
    assign wr_cmd  = cas_ok && (WEn != 4'hF);
    assign idx     = {row_q, A[COL_W-1:0]};
    assign rd_word = {Memory_byte3[idx], Memory_byte2[idx],
                      Memory_byte1[idx], Memory_byte0[idx]};

    // Storage and read-data pipeline. Neither is reset. The data pipe shifts
    // every cycle so that it stays aligned with vld_pipe_q, and only the valid
    // bits are flushed by reset.
    always_ff @(posedge CK) begin
        if (!RST && wr_cmd) begin
            if (!WEn[0]) Memory_byte0[idx] <= D[7:0];
            if (!WEn[1]) Memory_byte1[idx] <= D[15:8];
            if (!WEn[2]) Memory_byte2[idx] <= D[23:16];
            if (!WEn[3]) Memory_byte3[idx] <= D[31:24];
        end
        data_pipe_q[0] <= rd_word;
        for (int i = 1; i < CAS_LAT; i++)
            data_pipe_q[i] <= data_pipe_q[i-1];
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            prev_RASn  <= 1'b1;
            prev_CASn  <= 1'b1;
            row_open   <= 1'b0;
            row_q      <= '0;
            vld_pipe_q <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            prev_RASn <= RASn;
            prev_CASn <= CASn;
            if (act) begin
                row_q    <= A;
                row_open <= 1'b1;
            end else if (RASn) begin
                row_open <= 1'b0;
            end
            // The word is captured at the CAS edge into stage 0. It reaches
            // the output register CAS_LAT edges later.
            vld_pipe_q <= {vld_pipe_q[CAS_LAT-2:0], rd_cmd};
            valid_q    <= vld_pipe_q[CAS_LAT-1];
            if (vld_pipe_q[CAS_LAT-1])
                q_q <= data_pipe_q[CAS_LAT-1];
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_dram_device.sv
module tb_dram_device;

    localparam int CAS_LAT = 5;
    localparam int TRCD    = 2;

    logic        CK = 1'b0;
    logic        RST;
    logic        CSn;
    logic        RASn;
    logic        CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;

    dram_device dut (
        .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a word-addressed sparse memory plus the queue of
    // expected read returns, each tagged with the cycle it must appear on.
    typedef struct { int due; logic [31:0] data; } rd_t;
    logic [31:0] mem_m [int];
    rd_t         rq [$];
    rd_t         mon_r;
    bit          m_open   = 0;
    int          m_row    = 0;
    int          m_act    = 0;
    int          exp_viol = 0;
    logic [31:0] last_q   = '0;

    always @(negedge CK) begin
        if (VALID) begin
            if (rq.size() == 0) begin
                chk("spurious_valid", {31'b0, VALID}, 32'd0);
            end else begin
                mon_r = rq.pop_front();
                chk("rd_cycle", cyc, mon_r.due);
                chk("rd_data", Q, mon_r.data);
                last_q = mon_r.data;
            end
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                chk("valid_missing", {31'b0, VALID}, 32'd1);
                mon_r = rq.pop_front();
            end
            chk("q_hold", Q, last_q);
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle(input int n);
        CASn = 1'b1;
        repeat (n) step();
    endtask

    task automatic precharge();
        RASn = 1'b1; CASn = 1'b1;
        step();
        m_open = 0;
    endtask

    task automatic activate(input int row);
        precharge();
        RASn = 1'b0; A = row[10:0];
        step();
        m_open = 1; m_row = row; m_act = cyc;
    endtask

    task automatic cas(input int col, input logic [3:0] we, input logic [31:0] d, input bit csn);
        int          c;
        int          key;
        bit          ok;
        logic [31:0] w;
        CSn = csn; A = col[10:0]; WEn = we; D = d; CASn = 1'b0;
        step();
        c = cyc;
        CSn = 1'b0; CASn = 1'b1; WEn = 4'hF; A = 11'($urandom);
        step();
        ok = !csn && m_open;
`ifdef DRAM_TIMING_CHECK_EN
        if (!csn && (!m_open || (c - m_act) < TRCD)) begin
            ok = 0;
            exp_viol++;
        end
`endif
        key = (m_row << 10) | col;
        if (ok) begin
            if (we == 4'hF) begin
                rq.push_back('{due: c + CAS_LAT, data: mem_m[key]});
            end else begin
                w = mem_m.exists(key) ? mem_m[key] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (!we[i]) w[8*i +: 8] = d[8*i +: 8];
                mem_m[key] = w;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; RASn = 1'b1; CASn = 1'b1;
        rq.delete();
        m_open = 0; last_q = '0;
        exp_viol = 0;
        #1;
        chk("rst_q", Q, 32'h0);
        chk("rst_valid", {31'b0, VALID}, 32'd0);
        step(); step();
        RST = 1'b0;
        step();
    endtask

    function automatic logic [31:0] hier_word(input int k);
        return {dut.Memory_byte3[k], dut.Memory_byte2[k], dut.Memory_byte1[k], dut.Memory_byte0[k]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int rows [4] = '{32'h100, 32'h2A5, 32'h7FF, 32'h000};
    int cols [7] = '{0, 1, 2, 3, 4, 5, 32'h3FF};

    initial begin
        RST = 1'b1; CSn = 1'b0; RASn = 1'b1; CASn = 1'b1;
        WEn = 4'hF; A = '0; D = '0;
        step(); step(); step();
        chk("reset_q", Q, 32'h0);
        chk("reset_valid", {31'b0, VALID}, 32'd0);
        RST = 1'b0;
        step();

        // Preload through the write path.
        activate(32'h100); idle(1);
        cas(0, 4'h0, 32'hDEADBEEF, 0);
        cas(4, 4'h0, 32'hAAAAAAAA, 0);
        cas(1, 4'h0, 32'h00000001, 0);
        cas(2, 4'h0, 32'h00000002, 0);
        chk("hier_40000", hier_word(32'h40000), 32'hDEADBEEF);

        // Single read, latency and data checked by the monitor.
        cas(0, 4'hF, 32'h0, 0);
        idle(8);
        chk("rd1_drained", rq.size(), 0);
        chk("rd1_q", Q, 32'hDEADBEEF);

        // Byte-masked write, then read back.
        cas(4, 4'b1010, 32'h11223344, 0);
        chk("bytewr_novalid", {31'b0, VALID}, 32'd0);
        chk("hier_40004", hier_word(32'h40004), 32'hAA22AA44);
        cas(4, 4'hF, 32'h0, 0);
        idle(7);

        // Back-to-back reads, then a write chasing a read to the same word.
        cas(1, 4'hF, 32'h0, 0);
        cas(2, 4'hF, 32'h0, 0);
        cas(1, 4'hF, 32'h0, 0);
        cas(1, 4'h0, 32'h00000055, 0);
        cas(1, 4'hF, 32'h0, 0);
        // A read still in flight when the row is closed must complete.
        cas(2, 4'hF, 32'h0, 0);
        precharge();
        idle(8);
        chk("b2b_drained", rq.size(), 0);

        // CAS with the row closed, and CAS with the chip deselected.
        cas(0, 4'hF, 32'h0, 0);
        idle(8);
`ifdef DRAM_TIMING_CHECK_EN
        chk("viol_closed", dut.violation_count, exp_viol);
`endif
        activate(32'h100); idle(1);
        cas(0, 4'hF, 32'h0, 1);
        idle(8);

        // Reset while a read is pending.
        cas(0, 4'hF, 32'h0, 0);
        step();
        do_reset();
        idle(8);
        chk("hier_after_rst", hier_word(32'h40000), 32'hDEADBEEF);
        activate(32'h100); idle(1);
        cas(0, 4'hF, 32'h0, 0);
        idle(7);

        // CAS one cycle after activation.
        activate(32'h100);
        cas(2, 4'hF, 32'h0, 0);
        idle(7);
`ifdef DRAM_TIMING_CHECK_EN
        chk("viol_trcd", dut.violation_count, exp_viol);
`endif

        // Random traffic over a small row/column set, including the extremes.
        for (int it = 0; it < 300; it++) begin
            int op;
            int col;
            int key;
            op  = $urandom_range(0, 9);
            col = cols[$urandom_range(0, 6)];
            key = (m_row << 10) | col;
            case (op)
                0: activate(rows[$urandom_range(0, 3)]);
                1: precharge();
                2, 3: idle($urandom_range(0, 3));
                4, 5, 6: begin
                    if (m_open && !mem_m.exists(key))
                        cas(col, 4'h0, $urandom, 0);
                    else
                        cas(col, 4'hF, 32'h0, 0);
                end
                default: cas(col, 4'($urandom_range(0, 14)), $urandom, 0);
            endcase
        end
        idle(10);
        chk("rand_drained", rq.size(), 0);
`ifdef DRAM_TIMING_CHECK_EN
        chk("viol_final", dut.violation_count, exp_viol);
`endif
        chk("hier_final_40004", hier_word(32'h40004), mem_m[32'h40004]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
